// File: rtl/decode_stage.sv
// Decode stage: register file, per-register in-flight scoreboard, hazard and
// branch stall generation, and the DE/EX pipeline latch. All state advances on
// the falling edge of I_CLOCK; I_RESET clears everything asynchronously.
module decode_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int SB_MAX     = 3
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET,
  input  logic                        I_LOCK,
  input  logic [DATA_WIDTH-1:0]       I_PC,
  input  logic [31:0]                 I_IR,
  input  logic                        I_FetchStall,
  input  logic                        I_WriteBackEnable,
  input  logic [$clog2(NUM_REGS)-1:0] I_WriteBackRegIdx,
  input  logic [DATA_WIDTH-1:0]       I_WriteBackData,
  input  logic                        I_BranchAddrSelect,
  output logic                        O_LOCK,
  output logic [DATA_WIDTH-1:0]       O_PC,
  output logic [7:0]                  O_Opcode,
  output logic [$clog2(NUM_REGS)-1:0] O_DestRegIdx,
  output logic [DATA_WIDTH-1:0]       O_Src1Value,
  output logic [DATA_WIDTH-1:0]       O_Src2Value,
  output logic [DATA_WIDTH-1:0]       O_Imm,
  output logic                        O_FetchStall,
  output logic                        O_DepStallSignal,
  output logic                        O_BranchStallSignal
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int SB_W  = $clog2(SB_MAX + 1);

  // Instruction classes from IR[31:28]
  localparam logic [3:0] CLS_ALU_RR = 4'h0;
  localparam logic [3:0] CLS_ALU_IM = 4'h1;
  localparam logic [3:0] CLS_MOVI   = 4'h2;
  localparam logic [3:0] CLS_LDW    = 4'h3;
  localparam logic [3:0] CLS_STW    = 4'h4;
  localparam logic [3:0] CLS_BR     = 4'h5;
  localparam logic [3:0] CLS_JMP    = 4'h6;
  localparam logic [3:0] CLS_JSR    = 4'h7;

  localparam logic [7:0]       OPC_BUBBLE = 8'hFF;
  localparam logic [IDX_W-1:0] LINK_REG   = IDX_W'(7);

  // Architectural state
  logic [DATA_WIDTH-1:0] r_rf [NUM_REGS];
  logic [SB_W-1:0]       r_sb [NUM_REGS];
  logic [SB_W-1:0]       w_sb_next [NUM_REGS];
  logic                  r_branch_pending;

  // DE/EX latch
  logic                  r_lock;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [7:0]            r_opcode;
  logic [IDX_W-1:0]      r_dest;
  logic [DATA_WIDTH-1:0] r_src1;
  logic [DATA_WIDTH-1:0] r_src2;
  logic [DATA_WIDTH-1:0] r_imm;
  logic                  r_fetch_stall;

  // Decode signals
  logic [3:0]       w_cls;
  logic [IDX_W-1:0] w_dr;
  logic [IDX_W-1:0] w_sr1;
  logic [IDX_W-1:0] w_sr2;
  logic [IDX_W-1:0] w_dest;
  logic             w_rd1;
  logic             w_rd2;
  logic             w_wr;
  logic             w_br;
  logic             w_valid_in;
  logic             w_src1_busy;
  logic             w_src2_busy;
  logic             w_dest_full;
  logic             w_dep_stall;
  logic             w_issue;
  logic             w_unused;

  assign w_cls = I_IR[31:28];
  assign w_dr  = I_IR[20 +: IDX_W];
  assign w_sr1 = I_IR[16 +: IDX_W];
  assign w_sr2 = I_IR[8 +: IDX_W];

  // Bits of the instruction word that no class uses
  assign w_unused = ^{I_IR[23], I_IR[19]};

  // Per-class register usage and branch flag
  always_comb begin
    w_rd1 = 1'b0;
    w_rd2 = 1'b0;
    w_wr  = 1'b0;
    w_br  = 1'b0;
    case (w_cls)
      CLS_ALU_RR: begin w_rd1 = 1'b1; w_rd2 = 1'b1; w_wr = 1'b1; end
      CLS_ALU_IM: begin w_rd1 = 1'b1; w_wr = 1'b1; end
      CLS_MOVI:   begin w_wr = 1'b1; end
      CLS_LDW:    begin w_rd1 = 1'b1; w_wr = 1'b1; end
      CLS_STW:    begin w_rd1 = 1'b1; w_rd2 = 1'b1; end
      CLS_BR:     begin w_br = 1'b1; end
      CLS_JMP:    begin w_rd1 = 1'b1; w_br = 1'b1; end
      CLS_JSR:    begin w_wr = 1'b1; w_br = 1'b1; end
      default:    ;
    endcase
  end

  // JSR always links into the last register
  assign w_dest = (w_cls == CLS_JSR) ? LINK_REG : w_dr;

  assign w_valid_in = I_LOCK & ~I_FetchStall & ~r_branch_pending;

  // Hazard check uses current scoreboard only; a same-edge writeback does not bypass
  always_comb begin
    w_src1_busy = (r_sb[w_sr1] != '0);
    w_src2_busy = (r_sb[w_sr2] != '0);
    w_dest_full = (r_sb[w_dest] == SB_W'(SB_MAX));
    w_dep_stall = w_valid_in & ((w_rd1 & w_src1_busy) |
                                (w_rd2 & w_src2_busy) |
                                (w_wr & w_dest_full));
  end

  assign w_issue          = w_valid_in & ~w_dep_stall;
  assign O_DepStallSignal = w_dep_stall;

  // Scoreboard next state: issue increments, writeback decrements, both cancel
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      logic v_inc;
      logic v_dec;
      v_inc        = w_issue & w_wr & (w_dest == IDX_W'(i));
      v_dec        = I_WriteBackEnable & (I_WriteBackRegIdx == IDX_W'(i));
      w_sb_next[i] = r_sb[i];
      if (v_inc && !v_dec) begin
        w_sb_next[i] = r_sb[i] + SB_W'(1);
      end else if (v_dec && !v_inc && (r_sb[i] != '0)) begin
        w_sb_next[i] = r_sb[i] - SB_W'(1);
      end
    end
  end

  // Scoreboard counters
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_sb[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_sb[i] <= w_sb_next[i];
      end
    end
  end

  // Register file write port (writeback)
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (I_WriteBackEnable) begin
      r_rf[I_WriteBackRegIdx] <= I_WriteBackData;
    end
  end

  // Branch-in-flight flag; resolution wins over a new branch on the same edge
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      r_branch_pending <= 1'b0;
    end else if (I_BranchAddrSelect) begin
      r_branch_pending <= 1'b0;
    end else if (w_issue && w_br) begin
      r_branch_pending <= 1'b1;
    end
  end

  // DE/EX latch: decoded fields on issue, bubble otherwise
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      r_lock        <= 1'b0;
      r_pc          <= DATA_WIDTH'(4);
      r_opcode      <= OPC_BUBBLE;
      r_dest        <= '0;
      r_src1        <= '0;
      r_src2        <= '0;
      r_imm         <= '0;
      r_fetch_stall <= 1'b1;
    end else begin
      r_lock <= I_LOCK;
      r_pc   <= I_PC;
      if (w_issue) begin
        r_opcode      <= I_IR[31:24];
        r_dest        <= w_dest;
        r_src1        <= r_rf[w_sr1];
        r_src2        <= r_rf[w_sr2];
        r_imm         <= DATA_WIDTH'(I_IR[15:0]);
        r_fetch_stall <= 1'b0;
      end else begin
        r_opcode      <= OPC_BUBBLE;
        r_dest        <= '0;
        r_fetch_stall <= 1'b1;
      end
    end
  end

  // Output wiring
  always_comb begin
    O_LOCK              = r_lock;
    O_PC                = r_pc;
    O_Opcode            = r_opcode;
    O_DestRegIdx        = r_dest;
    O_Src1Value         = r_src1;
    O_Src2Value         = r_src2;
    O_Imm               = r_imm;
    O_FetchStall        = r_fetch_stall;
    O_BranchStallSignal = r_branch_pending;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios then random traffic, checked
// against a queue-based reference model through an expected-output scoreboard.
module tb_decode_stage;

  logic        I_CLOCK;
  logic        I_RESET;
  logic        I_LOCK;
  logic [15:0] I_PC;
  logic [31:0] I_IR;
  logic        I_FetchStall;
  logic        I_WriteBackEnable;
  logic [2:0]  I_WriteBackRegIdx;
  logic [15:0] I_WriteBackData;
  logic        I_BranchAddrSelect;
  logic        O_LOCK;
  logic [15:0] O_PC;
  logic [7:0]  O_Opcode;
  logic [2:0]  O_DestRegIdx;
  logic [15:0] O_Src1Value;
  logic [15:0] O_Src2Value;
  logic [15:0] O_Imm;
  logic        O_FetchStall;
  logic        O_DepStallSignal;
  logic        O_BranchStallSignal;

  decode_stage dut (
    .I_CLOCK            (I_CLOCK),
    .I_RESET            (I_RESET),
    .I_LOCK             (I_LOCK),
    .I_PC               (I_PC),
    .I_IR               (I_IR),
    .I_FetchStall       (I_FetchStall),
    .I_WriteBackEnable  (I_WriteBackEnable),
    .I_WriteBackRegIdx  (I_WriteBackRegIdx),
    .I_WriteBackData    (I_WriteBackData),
    .I_BranchAddrSelect (I_BranchAddrSelect),
    .O_LOCK             (O_LOCK),
    .O_PC               (O_PC),
    .O_Opcode           (O_Opcode),
    .O_DestRegIdx       (O_DestRegIdx),
    .O_Src1Value        (O_Src1Value),
    .O_Src2Value        (O_Src2Value),
    .O_Imm              (O_Imm),
    .O_FetchStall       (O_FetchStall),
    .O_DepStallSignal   (O_DepStallSignal),
    .O_BranchStallSignal(O_BranchStallSignal)
  );

  initial I_CLOCK = 1'b1;
  always #5 I_CLOCK = ~I_CLOCK;

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  dest;
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] imm;
    logic [15:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;

  // Reference model: register values, list of destinations still in flight,
  // and whether a branch is outstanding.
  logic [15:0] m_rf[8];
  int          inflight[$];
  bit          m_pending;
  logic [15:0] pc_ctr = 16'h0100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int cnt(input int r);
    int n = 0;
    foreach (inflight[i]) if (inflight[i] == r) n++;
    return n;
  endfunction

  task automatic classify(input logic [31:0] ir, output bit r1, output bit r2,
                          output bit w, output bit br);
    r1 = 0; r2 = 0; w = 0; br = 0;
    case (ir[31:28])
      4'h0: begin r1 = 1; r2 = 1; w = 1; end
      4'h1: begin r1 = 1; w = 1; end
      4'h2: w = 1;
      4'h3: begin r1 = 1; w = 1; end
      4'h4: begin r1 = 1; r2 = 1; end
      4'h5: br = 1;
      4'h6: begin r1 = 1; br = 1; end
      4'h7: begin w = 1; br = 1; end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] mk(input logic [7:0] op, input int dr, input int sr1,
                                     input logic [15:0] imm);
    return {op, 1'b0, 3'(dr), 1'b0, 3'(sr1), imm};
  endfunction

  task automatic model_reset();
    foreach (m_rf[i]) m_rf[i] = '0;
    inflight.delete();
    exp_q.delete();
    m_pending = 0;
  endtask

  // One pipeline cycle: drive, check the combinational stall, advance the
  // model, then confirm the registered flags after the falling edge.
  task automatic step(input bit lock, input logic [31:0] ir, input logic [15:0] pc,
                      input bit fs, input bit wbe, input int wbidx,
                      input logic [15:0] wbd, input bit bsel);
    bit r1, r2, w, br, valid, stall, issue;
    int sr1, sr2, dest;
    exp_t e;
    I_LOCK = lock; I_IR = ir; I_PC = pc; I_FetchStall = fs;
    I_WriteBackEnable = wbe; I_WriteBackRegIdx = 3'(wbidx); I_WriteBackData = wbd;
    I_BranchAddrSelect = bsel;
    #1;
    classify(ir, r1, r2, w, br);
    sr1   = int'(ir[18:16]);
    sr2   = int'(ir[10:8]);
    dest  = (ir[31:28] == 4'h7) ? 7 : int'(ir[22:20]);
    valid = lock && !fs && !m_pending;
    stall = valid && ((r1 && cnt(sr1) > 0) || (r2 && cnt(sr2) > 0) || (w && cnt(dest) >= 3));
    issue = valid && !stall;
    chk("dep_stall", {31'd0, O_DepStallSignal}, {31'd0, stall});
    if (issue) begin
      e.op = ir[31:24]; e.dest = 3'(dest); e.s1 = m_rf[sr1]; e.s2 = m_rf[sr2];
      e.imm = ir[15:0]; e.pc = pc;
      exp_q.push_back(e);
      if (w) inflight.push_back(dest);
    end
    if (wbe) begin
      m_rf[wbidx] = wbd;
      foreach (inflight[i]) begin
        if (inflight[i] == wbidx) begin
          inflight.delete(i);
          break;
        end
      end
    end
    if (bsel) m_pending = 0;
    else if (issue && br) m_pending = 1;
    @(negedge I_CLOCK);
    #1;
    chk("lock_out", {31'd0, O_LOCK}, {31'd0, lock});
    chk("branch_stall", {31'd0, O_BranchStallSignal}, {31'd0, m_pending});
    @(posedge I_CLOCK);
    #2;
  endtask

  task automatic issue_ir(input logic [31:0] ir);
    step(1, ir, pc_ctr, 0, 0, 0, 16'h0, 0);
    pc_ctr += 16'd4;
  endtask

  task automatic idle_wb(input int idx, input logic [15:0] d);
    step(0, 32'hFFFF_FFFF, pc_ctr, 1, 1, idx, d, 0);
  endtask

  task automatic do_reset();
    I_LOCK = 0; I_FetchStall = 1; I_WriteBackEnable = 0; I_BranchAddrSelect = 0;
    I_IR = 32'hFFFF_FFFF;
    I_RESET = 1;
    #1;
    chk("rst_branch_stall", {31'd0, O_BranchStallSignal}, 32'd0);
    chk("rst_fetch_stall", {31'd0, O_FetchStall}, 32'd1);
    chk("rst_opcode", {24'd0, O_Opcode}, 32'h0000_00FF);
    chk("rst_pc", {16'd0, O_PC}, 32'h0000_0004);
    chk("rst_lock", {31'd0, O_LOCK}, 32'd0);
    chk("rst_dest", {29'd0, O_DestRegIdx}, 32'd0);
    chk("rst_src1", {16'd0, O_Src1Value}, 32'd0);
    chk("rst_imm", {16'd0, O_Imm}, 32'd0);
    model_reset();
    I_RESET = 0;
    @(posedge I_CLOCK);
    #2;
  endtask

  // Monitor: every presented DE/EX instruction must match the oldest expectation
  always @(posedge I_CLOCK) begin
    if (mon_en && !I_RESET) begin
      if (O_FetchStall === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got opcode %h expected bubble", O_Opcode);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("opcode", {24'd0, O_Opcode}, {24'd0, e.op});
          chk("dest", {29'd0, O_DestRegIdx}, {29'd0, e.dest});
          chk("src1", {16'd0, O_Src1Value}, {16'd0, e.s1});
          chk("src2", {16'd0, O_Src2Value}, {16'd0, e.s2});
          chk("imm", {16'd0, O_Imm}, {16'd0, e.imm});
          chk("pc", {16'd0, O_PC}, {16'd0, e.pc});
        end
      end else begin
        chk("bubble_opcode", {24'd0, O_Opcode}, 32'h0000_00FF);
        chk("bubble_dest", {29'd0, O_DestRegIdx}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    I_RESET = 1; I_LOCK = 0; I_PC = 16'h0; I_IR = 32'hFFFF_FFFF; I_FetchStall = 1;
    I_WriteBackEnable = 0; I_WriteBackRegIdx = 3'd0; I_WriteBackData = 16'h0;
    I_BranchAddrSelect = 0;
    model_reset();
    @(posedge I_CLOCK);
    @(posedge I_CLOCK);
    #2;
    do_reset();
    mon_en = 1;

    // Independent stream
    issue_ir(mk(8'h20, 1, 0, 16'h0005));
    issue_ir(mk(8'h20, 2, 0, 16'h0007));
    idle_wb(1, 16'h0005);
    idle_wb(2, 16'h0007);

    // RAW hazard on R3, resolved by writeback with no bypass
    issue_ir(mk(8'h00, 3, 1, 16'h0200));
    issue_ir(mk(8'h00, 4, 3, 16'h0300));
    issue_ir(mk(8'h00, 4, 3, 16'h0300));
    step(1, mk(8'h00, 4, 3, 16'h0300), pc_ctr, 0, 1, 3, 16'h000C, 0);
    issue_ir(mk(8'h00, 4, 3, 16'h0300));
    idle_wb(4, 16'h0019);

    // Branch: bubbles while pending, resolution edge still drops its input
    issue_ir(mk(8'h50, 0, 0, 16'h0010));
    step(1, mk(8'h20, 6, 0, 16'h0001), pc_ctr, 0, 0, 0, 16'h0, 0);
    step(1, mk(8'h20, 6, 0, 16'h0002), pc_ctr, 1, 0, 0, 16'h0, 0);
    step(1, mk(8'h20, 6, 0, 16'h0003), pc_ctr, 0, 0, 0, 16'h0, 0);
    step(1, mk(8'h20, 6, 0, 16'h0004), pc_ctr, 0, 0, 0, 16'h0, 1);
    issue_ir(mk(8'h20, 6, 0, 16'h0005));
    idle_wb(6, 16'h0005);

    // Scoreboard saturation on R5
    for (int i = 0; i < 4; i++) issue_ir(mk(8'h21, 5, 0, 16'(16'h0050 + i)));
    step(1, mk(8'h21, 5, 0, 16'h0060), pc_ctr, 0, 1, 5, 16'h1111, 0);
    step(1, mk(8'h21, 5, 0, 16'h0061), pc_ctr, 0, 1, 5, 16'h2222, 0);
    issue_ir(mk(8'h21, 5, 0, 16'h0062));
    issue_ir(mk(8'h21, 5, 0, 16'h0063));
    while (inflight.size() > 0) idle_wb(inflight[0], 16'h5555);

    // Reset mid-run with R3 busy twice and a branch pending
    issue_ir(mk(8'h20, 3, 0, 16'h0031));
    issue_ir(mk(8'h20, 3, 0, 16'h0032));
    issue_ir(mk(8'h70, 0, 0, 16'h0040));
    do_reset();
    issue_ir(mk(8'h00, 4, 3, 16'h0300));
    idle_wb(4, 16'h0000);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      bit          lock, fs, wbe, bsel;
      int          cls, idx;
      logic [7:0]  op;
      logic [15:0] d;
      lock = ($urandom % 10) != 0;
      fs   = ($urandom % 5) == 0;
      cls  = int'($urandom % 10);
      if (cls < 8) op = {4'(cls), 4'($urandom)};
      else if ($urandom % 2) op = 8'hFF;
      else op = {4'($urandom_range(8, 15)), 4'($urandom)};
      wbe = 0; idx = 0; d = 16'($urandom);
      if (inflight.size() > 0 && ($urandom % 2)) begin
        wbe = 1; idx = inflight[0];
      end else if ($urandom % 8 == 0) begin
        idx = int'($urandom % 8);
        wbe = (cnt(idx) == 0);
      end
      bsel = m_pending ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
      step(lock, mk(op, int'($urandom % 8), int'($urandom % 8), 16'($urandom)),
           16'($urandom), fs, wbe, idx, d, bsel);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
